out_sel_decode: RTL

//  Router output-stage decoder: the inverse of the port-allocation translation.

---
 rtl/out_sel_decode_pkg.sv | 19 +
 rtl/out_sel_decode_sel_dec.sv | 27 ++
 rtl/out_sel_decode.sv | 123 ++++++++++++
 3 files changed

// File: rtl/out_sel_decode_pkg.sv
// Shared router-port constants for the output-stage select decoder.
// Replaces the global.v defines used by the allocator and crossbar.
package out_sel_decode_pkg;

  localparam int DEF_NUM_PORT     = 5;
  localparam int DEF_LOG_NUM_PORT = 3;
  localparam int DEF_CNT_W        = 16;
  localparam int SEL_NONE         = 7;

  typedef enum logic [DEF_LOG_NUM_PORT-1:0] {
    PORT_N    = 3'd0,
    PORT_E    = 3'd1,
    PORT_S    = 3'd2,
    PORT_W    = 3'd3,
    PORT_L    = 3'd4,
    PORT_NONE = 3'd7
  } port_e;

endpackage

// File: rtl/out_sel_decode_sel_dec.sv
// Combinational decode of one binary output code into a one-hot request.
// Codes past the last port (other than the "no port" code) flag illegal.
module sel_dec
  import out_sel_decode_pkg::*;
#(
  parameter int NUM_PORT     = DEF_NUM_PORT,
  parameter int LOG_NUM_PORT = DEF_LOG_NUM_PORT
) (
  input  logic                    i_valid,
  input  logic [LOG_NUM_PORT-1:0] i_code,
  output logic [NUM_PORT-1:0]     o_req,
  output logic                    o_illegal
);

  always_comb begin
    o_req     = '0;
    o_illegal = 1'b0;
    if (i_valid) begin
      if (int'(i_code) < NUM_PORT) begin
        o_req = NUM_PORT'(1) << i_code;
      end else if (int'(i_code) != SEL_NONE) begin
        o_illegal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_sel_decode.sv
// Router output-stage decoder: per-input codes -> registered one-hot crossbar columns.
// Optional per-output flit counters are built when OUT_SEL_STATS_EN is defined.
module out_sel_decode
  import out_sel_decode_pkg::*;
#(
  parameter int NUM_PORT     = DEF_NUM_PORT,
  parameter int LOG_NUM_PORT = DEF_LOG_NUM_PORT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [NUM_PORT-1:0]              in_valid,
  input  logic [NUM_PORT*LOG_NUM_PORT-1:0] in_sel,
  output logic [NUM_PORT*NUM_PORT-1:0]     xbar_sel,
  output logic [NUM_PORT-1:0]              out_valid,
  output logic                             conflict,
  output logic                             illegal_sel,
`ifdef OUT_SEL_STATS_EN
  output logic [NUM_PORT*CNT_W-1:0]        stat_cnt,
  input  logic                             stat_clr,
`endif
  input  logic                             err_clr
);

  logic [NUM_PORT-1:0]          w_req [NUM_PORT];
  logic [NUM_PORT-1:0]          w_ill;
  logic [NUM_PORT*NUM_PORT-1:0] w_xbar;
  logic [NUM_PORT-1:0]          w_outValid;
  logic                         w_conflict;
  logic                         w_illegal;

  logic [NUM_PORT*NUM_PORT-1:0] r_xbar;
  logic [NUM_PORT-1:0]          r_outValid;
  logic                         r_conflict;
  logic                         r_illegal;

  for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_dec
    sel_dec #(
      .NUM_PORT    (NUM_PORT),
      .LOG_NUM_PORT(LOG_NUM_PORT)
    ) u_selDec (
      .i_valid  (in_valid[gi]),
      .i_code   (in_sel[gi*LOG_NUM_PORT +: LOG_NUM_PORT]),
      .o_req    (w_req[gi]),
      .o_illegal(w_ill[gi])
    );
  end

  // Each output column grants its lowest-index requester; any extra requester is a conflict.
  always_comb begin : p_arb
    logic [NUM_PORT-1:0] col;
    w_xbar     = '0;
    w_outValid = '0;
    w_conflict = 1'b0;
    for (int o = 0; o < NUM_PORT; o++) begin
      col = '0;
      for (int i = 0; i < NUM_PORT; i++) begin
        col[i] = w_req[i][o];
      end
      w_xbar[o*NUM_PORT +: NUM_PORT] = col & (~col + NUM_PORT'(1));
      w_outValid[o] = |col;
      if ((col & (col - NUM_PORT'(1))) != '0) begin
        w_conflict = 1'b1;
      end
    end
    w_illegal = |w_ill;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_xbar     <= '0;
      r_outValid <= '0;
      r_conflict <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      if (en) begin
        r_xbar     <= w_xbar;
        r_outValid <= w_outValid;
      end
      // A fresh error outranks a clear landing in the same cycle.
      if (en && w_conflict) begin
        r_conflict <= 1'b1;
      end else if (err_clr) begin
        r_conflict <= 1'b0;
      end
      if (en && w_illegal) begin
        r_illegal <= 1'b1;
      end else if (err_clr) begin
        r_illegal <= 1'b0;
      end
    end
  end

  assign xbar_sel    = r_xbar;
  assign out_valid   = r_outValid;
  assign conflict    = r_conflict;
  assign illegal_sel = r_illegal;

`ifdef OUT_SEL_STATS_EN
  logic [CNT_W-1:0] r_cnt [NUM_PORT];

  // Counters saturate rather than wrap; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!reset || stat_clr) begin
      for (int o = 0; o < NUM_PORT; o++) begin
        r_cnt[o] <= '0;
      end
    end else if (en) begin
      for (int o = 0; o < NUM_PORT; o++) begin
        if (w_outValid[o] && (r_cnt[o] != '1)) begin
          r_cnt[o] <= r_cnt[o] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar go = 0; go < NUM_PORT; go++) begin : g_stat
    assign stat_cnt[go*CNT_W +: CNT_W] = r_cnt[go];
  end
`endif

endmodule
